// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: op codes, FSM states,
// byte-lane selects and small op-decoding helpers.
package mem_lsu_pkg;

  localparam int unsigned MemOpBus = 4;

  typedef enum logic [MemOpBus-1:0] {
    MemOpNone = 4'd0,
    MemOpLb   = 4'd1,
    MemOpLbu  = 4'd2,
    MemOpLh   = 4'd3,
    MemOpLhu  = 4'd4,
    MemOpLw   = 4'd5,
    MemOpSb   = 4'd6,
    MemOpSh   = 4'd7,
    MemOpSw   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SzNone = 2'd0,
    SzByte = 2'd1,
    SzHalf = 2'd2,
    SzWord = 2'd3
  } mem_size_e;

  // Big-endian lanes: byte 0 of a word lives in data[31:24].
  localparam logic [3:0] ByteSel0  = 4'b1000;
  localparam logic [3:0] HalfSel0  = 4'b1100;
  localparam logic [3:0] HalfSel1  = 4'b0011;
  localparam logic [3:0] WordSel   = 4'b1111;

  function automatic mem_size_e op_size(input mem_op_e op);
    case (op)
      MemOpLb, MemOpLbu, MemOpSb: return SzByte;
      MemOpLh, MemOpLhu, MemOpSh: return SzHalf;
      MemOpLw, MemOpSw:           return SzWord;
      default:                    return SzNone;
    endcase
  endfunction

  function automatic logic is_load(input mem_op_e op);
    return (op == MemOpLb) || (op == MemOpLbu) || (op == MemOpLh) ||
           (op == MemOpLhu) || (op == MemOpLw);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MemOpSb) || (op == MemOpSh) || (op == MemOpSw);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] addr_lo);
    case (op_size(op))
      SzHalf:  return addr_lo[0];
      SzWord:  return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus request/acknowledge interface between the LSU (master) and memory (slave).
interface mem_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_fmt.sv
// Combinational formatter: load lane extract/extend and store lane select/replication.
module mem_fmt
  import mem_lsu_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_sdata,
  output logic [31:0] o_ld_data,
  output logic [3:0]  o_sel,
  output logic [31:0] o_st_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    w_byte     = 8'h00;
    w_half     = 16'h0000;
    o_ld_data  = 32'h0;
    o_sel      = 4'b0000;
    o_st_wdata = 32'h0;

    case (i_addr_lo)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    case (i_op)
      MemOpLb:  o_ld_data = {{24{w_byte[7]}}, w_byte};
      MemOpLbu: o_ld_data = {24'h0, w_byte};
      MemOpLh:  o_ld_data = {{16{w_half[15]}}, w_half};
      MemOpLhu: o_ld_data = {16'h0, w_half};
      MemOpLw:  o_ld_data = i_rdata;
      default:  o_ld_data = 32'h0;
    endcase

    case (op_size(i_op))
      SzByte: begin
        o_sel      = ByteSel0 >> i_addr_lo;
        o_st_wdata = {4{i_sdata[7:0]}};
      end
      SzHalf: begin
        o_sel      = i_addr_lo[1] ? HalfSel1 : HalfSel0;
        o_st_wdata = {2{i_sdata[15:0]}};
      end
      SzWord: begin
        o_sel      = WordSel;
        o_st_wdata = i_sdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through, runs req/ack bus
// transactions for loads/stores and stalls the pipeline until they finish.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        stallreq,
  output logic        misalign,
  output logic        bus_err,
  mem_lsu_if.master   bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [31:0]      r_rdata;
  logic             r_bus_req;
  logic             r_bus_we;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_bus_sel;
  logic [31:0]      r_bus_wdata;

  mem_op_e     w_op;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_issue;
  logic        w_timeout;
  logic [31:0] w_ld_data;
  logic [3:0]  w_sel;
  logic [31:0] w_st_wdata;

  assign w_op         = mem_op_e'(mem_op);
  assign w_is_load    = is_load(w_op);
  assign w_is_store   = is_store(w_op);
  assign w_is_mem     = w_is_load || w_is_store;
  assign w_misaligned = w_is_mem && is_misaligned(w_op, mem_addr[1:0]);
  assign w_issue      = w_is_mem && !w_misaligned;
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  mem_fmt u_fmt (
    .i_op       (w_op),
    .i_addr_lo  (mem_addr[1:0]),
    .i_rdata    (bus.bus_rdata),
    .i_sdata    (mem_sdata),
    .o_ld_data  (w_ld_data),
    .o_sel      (w_sel),
    .o_st_wdata (w_st_wdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_sel   <= 4'b0000;
      r_bus_wdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {mem_addr[31:2], 2'b00};
            r_bus_sel   <= w_sel;
            r_bus_wdata <= w_is_store ? w_st_wdata : 32'h0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (bus.bus_ack) begin
            r_bus_req <= 1'b0;
            if (w_is_load) r_rdata <= w_ld_data;
            r_state   <= DONE;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stalled cycles present a bubble (wb_wreg=0) to MEM/WB.
  always_comb begin
    wb_wd    = mem_wd;
    wb_wreg  = 1'b0;
    wb_wdata = 32'h0;
    stallreq = 1'b0;
    misalign = 1'b0;
    bus_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_is_mem) begin
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end else if (w_misaligned) begin
          misalign = 1'b1;
        end else begin
          stallreq = 1'b1;
        end
      end
      BUSY: stallreq = 1'b1;
      DONE: begin
        if (r_err) begin
          bus_err = 1'b1;
        end else if (w_is_load) begin
          wb_wreg  = mem_wreg;
          wb_wdata = r_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_sel   = r_bus_sel;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with hand-computed expectations.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        stallreq;
  logic        misalign;
  logic        bus_err;

  mem_lsu_if bus_if ();

  mem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_wd    (mem_wd),
    .mem_wreg  (mem_wreg),
    .mem_wdata (mem_wdata),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .wb_wd     (wb_wd),
    .wb_wreg   (wb_wreg),
    .wb_wdata  (wb_wdata),
    .stallreq  (stallreq),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .bus       (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Values observed during the most recent access.
  int          stall_n, busy_n;
  logic        hung;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_we;
  logic        done_wreg, done_err, done_mis, done_req;
  logic [4:0]  done_wd;
  logic [31:0] done_wdata;

  // Presents an op at a negedge and walks it to its final (non-stalled) cycle.
  // n_wait = BUSY cycles without ack before the acked one; -1 = never ack.
  task automatic run_access(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [4:0] wd, input int n_wait, input logic [31:0] rdata);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_sdata = sdata;
    mem_wd = wd; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
    #1;
    stall_n = 0; busy_n = 0; hung = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!stallreq) begin
        hung = 1'b0;
        break;
      end
      stall_n++;
      if (bus_if.bus_req) begin
        if (busy_n == 0) begin
          cap_addr = bus_if.bus_addr; cap_sel = bus_if.bus_sel;
          cap_we = bus_if.bus_we;     cap_wdata = bus_if.bus_wdata;
        end
        bus_if.bus_ack   = (n_wait >= 0) && (busy_n == n_wait);
        bus_if.bus_rdata = rdata;
        busy_n++;
      end
      @(negedge clk);
      bus_if.bus_ack = 1'b0;
      #1;
    end
    done_wreg = wb_wreg; done_wd = wb_wd; done_wdata = wb_wdata;
    done_err = bus_err; done_mis = misalign; done_req = bus_if.bus_req;
    mem_op = MemOpNone;
  endtask

  typedef struct {
    mem_op_e     op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          n_wait;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;  // load: write-back value; store: bus_wdata
    int          exp_stall;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{MemOpLb,  32'h102, 32'h0,         32'h11228033, 1, 32'h100, 4'b0010, 32'hFFFFFF80, 3};
    vecs[1] = '{MemOpSh,  32'h042, 32'hAAAA5678,  32'h0,        0, 32'h040, 4'b0011, 32'h56785678, 2};
    vecs[2] = '{MemOpLw,  32'h200, 32'h0,         32'hCAFEBABE, 0, 32'h200, 4'b1111, 32'hCAFEBABE, 2};
    vecs[3] = '{MemOpLhu, 32'h000, 32'h0,         32'h80012345, 2, 32'h000, 4'b1100, 32'h00008001, 4};
    vecs[4] = '{MemOpLh,  32'h002, 32'h0,         32'h12348765, 0, 32'h000, 4'b0011, 32'hFFFF8765, 2};
    vecs[5] = '{MemOpLbu, 32'h003, 32'h0,         32'h000000F0, 0, 32'h000, 4'b0001, 32'h000000F0, 2};
    vecs[6] = '{MemOpSb,  32'h001, 32'h123456AB,  32'h0,        0, 32'h000, 4'b0100, 32'hABABABAB, 2};
    vecs[7] = '{MemOpSw,  32'h008, 32'h01020304,  32'h0,        0, 32'h008, 4'b1111, 32'h01020304, 2};
    vecs[8] = '{MemOpLb,  32'h001, 32'h0,         32'h007F0000, 0, 32'h000, 4'b0100, 32'h0000007F, 2};

    rst = 1'b1;
    mem_op = MemOpNone; mem_addr = 32'h0; mem_sdata = 32'h0;
    mem_wd = 5'd0; mem_wreg = 1'b0; mem_wdata = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    #2 rst = 1'b0;
    #1;
    check("rst_req",  32'(bus_if.bus_req),  32'h0);
    check("rst_addr", bus_if.bus_addr,      32'h0);
    check("rst_sel",  32'(bus_if.bus_sel),  32'h0);
    check("rst_stall", 32'(stallreq),       32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Pass-through, plus an ack outside BUSY that must be ignored.
    @(negedge clk);
    mem_op = MemOpNone; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234;
    bus_if.bus_ack = 1'b1;
    #1;
    check("pt_wd",    32'(wb_wd),    32'd5);
    check("pt_wreg",  32'(wb_wreg),  32'd1);
    check("pt_wdata", wb_wdata,      32'h1234);
    check("pt_stall", 32'(stallreq), 32'h0);
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    #1;
    check("pt_noreq", 32'(bus_if.bus_req), 32'h0);

    foreach (vecs[i]) begin
      run_access(vecs[i].op, vecs[i].addr, vecs[i].sdata, 5'(i + 3), vecs[i].n_wait, vecs[i].rdata);
      check($sformatf("v%0d_hang", i),  32'(hung),    32'h0);
      check($sformatf("v%0d_stall", i), stall_n,      vecs[i].exp_stall);
      check($sformatf("v%0d_baddr", i), cap_addr,     vecs[i].exp_baddr);
      check($sformatf("v%0d_sel", i),   32'(cap_sel), 32'(vecs[i].exp_sel));
      check($sformatf("v%0d_err", i),   32'(done_err), 32'h0);
      check($sformatf("v%0d_reqoff", i), 32'(done_req), 32'h0);
      if (is_store(vecs[i].op)) begin
        check($sformatf("v%0d_we", i),     32'(cap_we),    32'h1);
        check($sformatf("v%0d_bwdata", i), cap_wdata,      vecs[i].exp_data);
        check($sformatf("v%0d_wreg", i),   32'(done_wreg), 32'h0);
      end else begin
        check($sformatf("v%0d_we", i),    32'(cap_we),    32'h0);
        check($sformatf("v%0d_wreg", i),  32'(done_wreg), 32'h1);
        check($sformatf("v%0d_wd", i),    32'(done_wd),   32'(i + 3));
        check($sformatf("v%0d_wdata", i), done_wdata,     vecs[i].exp_data);
      end
    end

    // Misaligned LW: flagged for one cycle, never reaches the bus.
    run_access(MemOpLw, 32'h6, 32'h0, 5'd9, 0, 32'h0);
    check("mis_stall", stall_n,          0);
    check("mis_flag",  32'(done_mis),    32'h1);
    check("mis_wreg",  32'(done_wreg),   32'h0);
    check("mis_wd",    32'(done_wd),     32'd9);
    check("mis_wdata", done_wdata,       32'h0);
    check("mis_req",   32'(done_req),    32'h0);
    @(negedge clk); #1;
    check("mis_clear", 32'(misalign),    32'h0);
    check("mis_req2",  32'(bus_if.bus_req), 32'h0);

    // Timeout with TIMEOUT_CYCLES=4: four BUSY cycles, then an error DONE.
    run_access(MemOpLw, 32'h10, 32'h0, 5'd11, -1, 32'h0);
    check("to_hang",  32'(hung),      32'h0);
    check("to_busy",  busy_n,         4);
    check("to_stall", stall_n,        5);
    check("to_err",   32'(done_err),  32'h1);
    check("to_wreg",  32'(done_wreg), 32'h0);
    check("to_req",   32'(done_req),  32'h0);
    @(negedge clk); #1;
    check("to_errclr", 32'(bus_err),  32'h0);
    check("to_idle",   32'(stallreq), 32'h0);

    // Reset in the middle of BUSY drops the request without waiting for an edge.
    @(negedge clk);
    mem_op = MemOpLw; mem_addr = 32'h300; mem_wd = 5'd12; mem_wreg = 1'b1;
    @(negedge clk); #1;
    check("mr_busy", 32'(bus_if.bus_req), 32'h1);
    #2;
    rst = 1'b0; mem_op = MemOpNone;
    #1;
    check("mr_req",   32'(bus_if.bus_req),  32'h0);
    check("mr_stall", 32'(stallreq),        32'h0);
    check("mr_addr",  bus_if.bus_addr,      32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_access(MemOpLw, 32'h304, 32'h0, 5'd13, 0, 32'h5A5A0F0F);
    check("mr_hang",  32'(hung),      32'h0);
    check("mr_stall2", stall_n,       2);
    check("mr_baddr", cap_addr,       32'h304);
    check("mr_wreg",  32'(done_wreg), 32'h1);
    check("mr_wdata", done_wdata,     32'h5A5A0F0F);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
